skew_tile_feeder: RTL and testbench
===================================

Name: skew_tile_feeder

Overview:
Parametrised successor to the single-lane row shifter used to feed the systolic MAC array. Accepts a DIM x DIM operand tile one row per handshake into a ping-pong (two-bank) buffer. Drains the tile onto DIM lanes with a per-lane diagonal skew, so lane i is delayed i beats and zeros fill the gaps. A per-tile mode selects row-major or transposed drain. One bank loads while the other drains, so back-to-back tiles need no bubbles.

Parameters:
DIM, 8, tile dimension and lane count (>=2)
BITS, 8, element width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_row/in_tr valid
in_ready  output  1  feeder can accept a row
in_row  input  [DIM-1:0][BITS-1:0]  one tile row; element j = A[r][j]
in_tr  input  1  transpose mode; sampled only with row 0 of a tile
out_valid  output  1  out_data beat valid
out_ready  input  1  downstream accepts beat
out_data  output  [DIM-1:0][BITS-1:0]  skewed lane data
out_lane_vld  output  [DIM-1:0]  lane i carries a real element (not skew zero)
out_last  output  1  final beat of a tile
busy  output  1  any bank not EMPTY

Behaviour:
- Reset: all outputs 0 except in_ready=1; both banks EMPTY; storage cleared to 0; write bank = 0, read bank = 0.
- Bank FSM, one per bank: EMPTY -> FILL (row 0 accepted) -> FULL (row DIM-1 accepted) -> DRAIN (selected by the read side) -> EMPTY (out_last beat accepted).
- Write side:
  - Row counter wr_row counts 0..DIM-1 into the write bank.
  - Accept when in_valid && in_ready.
  - in_ready = write bank is EMPTY or FILL.
  - After row DIM-1, the write bank toggles.
  - in_tr is latched per bank at row 0.
- Read side:
  - When the read bank is FULL and the output register is empty or advancing, start the drain with beat counter k = 0.
  - The drain has 2*DIM-1 beats, k = 0..2*DIM-2.
  - Lane i at beat k: d = k - i. If 0 <= d < DIM, data = A[i][d] (tr=0) or A[d][i] (tr=1) and out_lane_vld[i] = 1. Otherwise data = 0 and out_lane_vld[i] = 0.
  - out_last = 1 at k = 2*DIM-2.
  - After the out_last beat is accepted, the bank goes EMPTY and the read bank toggles.
- Output register:
  - out_data, out_lane_vld, out_last and out_valid are registered.
  - While out_valid && !out_ready, all four hold stable (no change, no skipped k).
  - First beat latency: out_valid rises the cycle after the clock edge that accepts row DIM-1, provided the output register is free.
- Back-to-back tiles: when the next bank is FULL at out_last acceptance, its k = 0 beat follows in the next cycle with no idle cycle.
- Simultaneous events:
  - A row may be written to one bank in the same cycle the other bank drains.
  - A bank leaving DRAIN and another entering FILL in the same cycle is legal.
  - The write side never targets the bank in DRAIN.
- Full condition: both banks FULL or DRAIN gives in_ready = 0. in_ready reasserts the cycle after the out_last beat is accepted.
- Empty condition: out_valid = 0 and no spurious beats.
- Reset mid-operation: asynchronous return to reset state. A partial tile is discarded and out_valid drops immediately.
- Widths:
  - Counters are $clog2(DIM) bits for rows and $clog2(2*DIM-1) bits for beats.
  - The skew comparison uses signed or wider arithmetic so k - i never wraps.

Decomposition:
- Shared package feeder_pkg holds:
  - the bank-state enum bank_st_e {EMPTY, FILL, FULL, DRAIN};
  - the function beat_count(DIM) = 2*DIM-1.
- One natural sub-module, feeder_bank: one DIM x DIM storage bank with row write port, per-bank tr flag, and a combinational skewed read of all lanes for a given k.
- The top instantiates two feeder_bank instances plus the control FSMs and the output register.

Test Plan:
- Single tile, DIM=4, tr=0, A[r][c] = 16r+c, out_ready=1 -> 7 beats:
  - beat0 = {0,0,0,0x00} with lane_vld=0001;
  - beat3 = {0x30,0x21,0x12,0x03} with lane_vld=1111;
  - beat6 = {0x33,0,0,0} with lane_vld=1000 and out_last=1.
- Same tile with tr=1 -> beat3 lanes {0x03,0x12,0x21,0x30} (lane3..lane0); beat1 lane1 = A[0][1] = 0x01.
- Three tiles streamed with in_valid held 1 -> exactly 21 contiguous out_valid beats, no gaps between tiles.
  - in_ready drops after tile 2 completes while tile 1 drains.
  - in_ready reasserts the cycle after tile 1's out_last is accepted.
- Random out_ready stalls at 50% -> out_data holds stable under stall; beat sequence identical to the no-stall golden model.
- rst_n asserted after row 2 of a tile, then a fresh tile -> out_valid=0 immediately, no partial output; the fresh tile drains correctly with tr re-sampled.
- DIM=2, BITS=16 build -> 3-beat drain; boundary values 0xFFFF pass intact; out_last on beat 2.

Source files
------------

// File: rtl/feeder_pkg.sv
// feeder_pkg: shared types and helpers for the skewed tile feeder.
//   bank_st_e  - per-bank lifecycle: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY
//   beat_count - number of skewed output beats needed to drain one DIM x DIM tile
package feeder_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_st_e;

  function automatic int beat_count(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/feeder_bank.sv
// feeder_bank: one DIM x DIM storage bank of the ping-pong tile buffer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears storage and tr)
//   wr_en       - write wr_data into row wr_row this cycle
//   wr_row      - row index being written
//   wr_data     - one tile row, element j = A[r][j]
//   tr_in       - transpose flag, latched together with row 0
//   rd_k        - beat index for the combinational skewed read
//   rd_data     - lane i carries A[i][k-i] (or A[k-i][i] when transposed), else 0
//   rd_vld      - lane i carries a real element at beat rd_k
module feeder_bank
  import feeder_pkg::*;
#(
  parameter int DIM  = 8,
  parameter int BITS = 8,
  localparam int RW = $clog2(DIM),
  localparam int KW = $clog2(beat_count(DIM))
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [RW-1:0]            wr_row,
  input  logic [DIM-1:0][BITS-1:0] wr_data,
  input  logic                     tr_in,
  input  logic [KW-1:0]            rd_k,
  output logic [DIM-1:0][BITS-1:0] rd_data,
  output logic [DIM-1:0]           rd_vld
);

  logic [DIM-1:0][BITS-1:0] mem [DIM];
  logic                     tr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        mem[r] <= '0;
      end
      tr <= 1'b0;
    end else if (wr_en) begin
      mem[wr_row] <= wr_data;
      if (wr_row == '0) begin
        tr <= tr_in;
      end
    end
  end

  // d = k - i is formed two bits wider than k and signed, so lanes whose
  // diagonal has not started yet see a negative value instead of a wrap.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic signed [KW+1:0] d;
    logic [RW-1:0]        dx;
    logic                 hit;

    assign d          = $signed({2'b00, rd_k}) - $signed((KW+2)'(i));
    assign hit        = !d[KW+1] && (d < $signed((KW+2)'(DIM)));
    assign dx         = d[RW-1:0];
    assign rd_vld[i]  = hit;
    assign rd_data[i] = !hit ? '0 : (tr ? mem[dx][i] : mem[i][dx]);
  end

endmodule

// File: rtl/skew_tile_feeder.sv
// skew_tile_feeder: accepts a DIM x DIM tile one row per handshake into a
// two-bank ping-pong buffer and drains it onto DIM lanes with a diagonal
// skew (lane i delayed i beats, zeros in the gaps), row-major or transposed.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   in_valid      - in_row / in_tr valid
//   in_ready      - write bank is EMPTY or FILL
//   in_row        - one tile row, element j = A[r][j]
//   in_tr         - transpose mode, sampled with row 0 only
//   out_valid     - registered beat valid
//   out_ready     - downstream accepts beat
//   out_data      - skewed lane data
//   out_lane_vld  - lane carries a real element
//   out_last      - final beat of a tile
//   busy          - any bank not EMPTY
module skew_tile_feeder
  import feeder_pkg::*;
#(
  parameter int DIM  = 8,
  parameter int BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIM-1:0][BITS-1:0] in_row,
  input  logic                     in_tr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM-1:0][BITS-1:0] out_data,
  output logic [DIM-1:0]           out_lane_vld,
  output logic                     out_last,
  output logic                     busy
);

  localparam int NBEATS = beat_count(DIM);
  localparam int RW     = $clog2(DIM);
  localparam int KW     = $clog2(NBEATS);
  localparam logic [RW-1:0] LAST_ROW = RW'(DIM - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(NBEATS - 1);

  bank_st_e                 st [2];
  logic                     wr_bank;
  logic                     rd_bank;
  logic [RW-1:0]            wr_row;
  logic [KW-1:0]            k;

  logic                     wr_fire;
  logic                     out_adv;
  logic                     fire_last;
  logic                     load_en;
  logic                     load_start;
  logic                     load_src;
  logic [KW-1:0]            load_k;

  logic [DIM-1:0][BITS-1:0] bank_data [2];
  logic [DIM-1:0]           bank_vld  [2];

  assign in_ready  = (st[wr_bank] == EMPTY) || (st[wr_bank] == FILL);
  assign wr_fire   = in_valid && in_ready;
  assign out_adv   = !out_valid || out_ready;
  assign fire_last = out_valid && out_ready && out_last;
  assign busy      = (st[0] != EMPTY) || (st[1] != EMPTY);

  // Picks which bank and beat index feed the output register this cycle.
  // When the last beat of a tile leaves, the other bank may start at k = 0
  // in the same edge, which is what keeps back-to-back tiles bubble-free.
  always_comb begin
    load_en    = 1'b0;
    load_start = 1'b0;
    load_src   = rd_bank;
    load_k     = k;
    if (out_adv) begin
      if (fire_last) begin
        load_src = ~rd_bank;
        load_k   = '0;
        if (st[~rd_bank] == FULL) begin
          load_en    = 1'b1;
          load_start = 1'b1;
        end
      end else if (st[rd_bank] == DRAIN) begin
        load_en = 1'b1;
      end else if (st[rd_bank] == FULL) begin
        load_en    = 1'b1;
        load_start = 1'b1;
        load_k     = '0;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    feeder_bank #(
      .DIM  (DIM),
      .BITS (BITS)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_fire && (wr_bank == 1'(b))),
      .wr_row  (wr_row),
      .wr_data (in_row),
      .tr_in   (in_tr),
      .rd_k    (load_k),
      .rd_data (bank_data[b]),
      .rd_vld  (bank_vld[b])
    );
  end

  // The write, drain-finish and drain-start transitions always touch
  // different banks (EMPTY/FILL, DRAIN and FULL respectively), so the
  // three state updates below never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0]        <= EMPTY;
      st[1]        <= EMPTY;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_row       <= '0;
      k            <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_lane_vld <= '0;
      out_last     <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_row == LAST_ROW) begin
          st[wr_bank] <= FULL;
          wr_row      <= '0;
          wr_bank     <= ~wr_bank;
        end else begin
          if (wr_row == '0) begin
            st[wr_bank] <= FILL;
          end
          wr_row <= wr_row + 1'b1;
        end
      end

      if (fire_last) begin
        st[rd_bank] <= EMPTY;
        rd_bank     <= ~rd_bank;
      end

      if (load_start) begin
        st[load_src] <= DRAIN;
      end

      if (load_en) begin
        out_valid    <= 1'b1;
        out_data     <= bank_data[load_src];
        out_lane_vld <= bank_vld[load_src];
        out_last     <= (load_k == LAST_K);
        k            <= (load_k == LAST_K) ? '0 : load_k + 1'b1;
      end else if (out_adv) begin
        out_valid    <= 1'b0;
        out_data     <= '0;
        out_lane_vld <= '0;
        out_last     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_skew_tile_feeder.sv
// tb_skew_tile_feeder: directed self-checking bench for skew_tile_feeder.
// Main instance DIM=4/BITS=8, second instance DIM=2/BITS=16.
module tb_skew_tile_feeder;

  localparam int DIM  = 4;
  localparam int BITS = 8;

  typedef logic [DIM-1:0][DIM-1:0][BITS-1:0] tile_t;
  typedef struct packed {
    logic [DIM*BITS-1:0] data;
    logic [DIM-1:0]      vld;
    logic                last;
  } beat_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  vld;
    logic        last;
  } beat2_t;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [DIM-1:0][BITS-1:0] in_row;
  logic                     in_tr;
  logic                     out_valid;
  logic                     out_ready;
  logic [DIM-1:0][BITS-1:0] out_data;
  logic [DIM-1:0]           out_lane_vld;
  logic                     out_last;
  logic                     busy;

  logic                     in_valid2;
  logic                     in_ready2;
  logic [1:0][15:0]         in_row2;
  logic                     in_tr2;
  logic                     out_valid2;
  logic                     out_ready2;
  logic [1:0][15:0]         out_data2;
  logic [1:0]               out_lane_vld2;
  logic                     out_last2;
  logic                     busy2;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  beat_t  got[$];
  int     got_cyc[$];
  int     last_cyc[$];
  int     rise_cyc[$];
  beat2_t got2[$];
  logic   stall_chk;
  logic   prev_hold;
  logic   prev_in_ready;
  beat_t  prev_beat;

  skew_tile_feeder #(.DIM(DIM), .BITS(BITS)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row       (in_row),
    .in_tr        (in_tr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_lane_vld (out_lane_vld),
    .out_last     (out_last),
    .busy         (busy)
  );

  skew_tile_feeder #(.DIM(2), .BITS(16)) u_dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid2),
    .in_ready     (in_ready2),
    .in_row       (in_row2),
    .in_tr        (in_tr2),
    .out_valid    (out_valid2),
    .out_ready    (out_ready2),
    .out_data     (out_data2),
    .out_lane_vld (out_lane_vld2),
    .out_last     (out_last2),
    .busy         (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepted-beat collector, stall stability and in_ready rise tracking.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_chk && prev_hold) begin
        checkOutput("stall_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_hold", 64'({out_data, out_lane_vld, out_last}), 64'(prev_beat));
      end
      prev_hold = out_valid && !out_ready;
      prev_beat = {out_data, out_lane_vld, out_last};
      if (out_valid && out_ready) begin
        got.push_back({out_data, out_lane_vld, out_last});
        got_cyc.push_back(cyc);
        if (out_last) last_cyc.push_back(cyc);
      end
      if (in_ready && !prev_in_ready) rise_cyc.push_back(cyc);
      prev_in_ready = in_ready;
      if (out_valid2 && out_ready2) got2.push_back({out_data2, out_lane_vld2, out_last2});
    end else begin
      prev_hold     = 1'b0;
      prev_in_ready = 1'b1;
    end
  end

  function automatic tile_t mkTile(input logic [7:0] base);
    tile_t t;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        t[r][c] = base + 8'(16 * r + c);
    return t;
  endfunction

  // Reference beat: lane i holds element (i, k-i) of A or of A transposed.
  function automatic beat_t model(input tile_t t, input logic tr, input int k);
    beat_t b;
    b = '0;
    for (int i = 0; i < DIM; i++) begin
      int d;
      d = k - i;
      if (d >= 0 && d < DIM) begin
        b.data[i*BITS +: BITS] = tr ? t[d][i] : t[i][d];
        b.vld[i] = 1'b1;
      end
    end
    b.last = (k == 2 * DIM - 2);
    return b;
  endfunction

  task automatic applyStimulus(input tile_t t, input logic tr, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      int w;
      in_valid = 1'b1;
      in_row   = t[r];
      in_tr    = (r == 0) ? tr : ~tr;
      w = 0;
      while (!in_ready && w < 200) begin
        @(posedge clk); #2;
        w++;
      end
      if (w >= 200) checkOutput("in_ready_tmo", 64'(in_ready), 64'd1);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    in_row   = '0;
  endtask

  task automatic drainBeats(input string tag, input int n, input logic stall);
    int w;
    w = 0;
    while (got.size() < n && w < 1000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #2;
      w++;
    end
    out_ready = 1'b1;
    checkOutput(tag, 64'(got.size()), 64'(n));
  endtask

  task automatic checkTile(input string tag, input tile_t t, input logic tr, input int base);
    for (int k = 0; k < 2 * DIM - 1; k++) begin
      beat_t g;
      g = (base + k < got.size()) ? got[base + k] : '1;
      checkOutput($sformatf("%s_k%0d", tag, k), 64'(g), 64'(model(t, tr, k)));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    tile_t ta, tb, tc, td, te, tf, tg, th;
    ta = mkTile(8'h00);
    tb = mkTile(8'h40);
    tc = mkTile(8'h80);
    td = mkTile(8'hC0);
    te = mkTile(8'h05);
    tf = mkTile(8'hA0);
    tg = mkTile(8'h50);
    th = mkTile(8'h11);

    rst_n = 1'b0; in_valid = 1'b0; in_row = '0; in_tr = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_row2 = '0; in_tr2 = 1'b0; out_ready2 = 1'b1;
    stall_chk = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_lane_vld", 64'(out_lane_vld), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Single tile, row-major
    $display("[TB] single tile tr=0");
    got.delete();
    applyStimulus(ta, 1'b0, 4);
    checkOutput("lat_pre", 64'(out_valid), 64'd0);
    checkOutput("busy_full", 64'(busy), 64'd1);
    @(posedge clk); #2;
    checkOutput("lat_first", 64'(out_valid), 64'd1);
    drainBeats("t1_nbeats", 7, 1'b0);
    if (got.size() >= 7) begin
      checkOutput("t1_b0_data", 64'(got[0].data), 64'h0000_0000);
      checkOutput("t1_b0_vld", 64'(got[0].vld), 64'h1);
      checkOutput("t1_b3_data", 64'(got[3].data), 64'h3021_1203);
      checkOutput("t1_b3_vld", 64'(got[3].vld), 64'hF);
      checkOutput("t1_b6_data", 64'(got[6].data), 64'h3300_0000);
      checkOutput("t1_b6_vld", 64'(got[6].vld), 64'h8);
      checkOutput("t1_b6_last", 64'(got[6].last), 64'h1);
    end
    checkTile("t1", ta, 1'b0, 0);
    repeat (3) begin @(posedge clk); #2; end
    checkOutput("t1_idle_valid", 64'(out_valid), 64'd0);
    checkOutput("t1_no_extra", 64'(got.size()), 64'd7);
    checkOutput("t1_idle_busy", 64'(busy), 64'd0);

    // Same tile, transposed
    $display("[TB] single tile tr=1");
    got.delete();
    applyStimulus(ta, 1'b1, 4);
    drainBeats("t2_nbeats", 7, 1'b0);
    if (got.size() >= 7) begin
      checkOutput("t2_b3_data", 64'(got[3].data), 64'h0312_2130);
      checkOutput("t2_b1_lane1", 64'(got[1].data[15:8]), 64'h01);
      checkOutput("t2_b1_lane0", 64'(got[1].data[7:0]), 64'h10);
    end
    checkTile("t2", ta, 1'b1, 0);

    // Three back-to-back tiles
    $display("[TB] three streamed tiles");
    got.delete(); got_cyc.delete(); last_cyc.delete(); rise_cyc.delete();
    applyStimulus(tb, 1'b0, 4);
    applyStimulus(tc, 1'b1, 4);
    checkOutput("s_inrdy_low", 64'(in_ready), 64'd0);
    checkOutput("s_draining", 64'(out_valid), 64'd1);
    applyStimulus(td, 1'b0, 4);
    drainBeats("s_nbeats", 21, 1'b0);
    if (got_cyc.size() >= 21)
      checkOutput("s_contig", 64'(got_cyc[20] - got_cyc[0]), 64'd20);
    if (rise_cyc.size() > 0 && last_cyc.size() > 0)
      checkOutput("s_inrdy_rise", 64'(rise_cyc[0]), 64'(last_cyc[0] + 1));
    else
      checkOutput("s_inrdy_seen", 64'(rise_cyc.size() > 0 && last_cyc.size() > 0), 64'd1);
    checkTile("s0", tb, 1'b0, 0);
    checkTile("s1", tc, 1'b1, 7);
    checkTile("s2", td, 1'b0, 14);

    // Random downstream stalls
    $display("[TB] stalled drain");
    got.delete();
    stall_chk = 1'b1;
    applyStimulus(te, 1'b1, 4);
    drainBeats("st_nbeats", 7, 1'b1);
    stall_chk = 1'b0;
    checkTile("st", te, 1'b1, 0);
    repeat (3) begin @(posedge clk); #2; end
    checkOutput("st_idle_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a partial tile
    $display("[TB] reset mid-tile");
    got.delete();
    applyStimulus(tg, 1'b1, 4);
    applyStimulus(tf, 1'b1, 3);
    checkOutput("r_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("r_valid_drop", 64'(out_valid), 64'd0);
    checkOutput("r_in_ready", 64'(in_ready), 64'd1);
    checkOutput("r_busy", 64'(busy), 64'd0);
    checkOutput("r_lane_vld", 64'(out_lane_vld), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    got.delete();
    @(posedge clk); #2;
    applyStimulus(th, 1'b0, 4);
    drainBeats("rs_nbeats", 7, 1'b0);
    checkTile("rs", th, 1'b0, 0);
    repeat (4) begin @(posedge clk); #2; end
    checkOutput("rs_no_extra", 64'(got.size()), 64'd7);

    // DIM=2, BITS=16 instance
    $display("[TB] DIM=2 BITS=16");
    got2.delete();
    checkOutput("d2_inrdy", 64'(in_ready2), 64'd1);
    in_valid2 = 1'b1;
    in_tr2    = 1'b0;
    in_row2   = {16'h1234, 16'hFFFF};
    @(posedge clk); #2;
    in_row2   = {16'hFFFF, 16'h8000};
    @(posedge clk); #2;
    in_valid2 = 1'b0;
    in_row2   = '0;
    begin
      int w;
      w = 0;
      while (got2.size() < 3 && w < 100) begin
        @(posedge clk); #2;
        w++;
      end
    end
    checkOutput("d2_nbeats", 64'(got2.size()), 64'd3);
    if (got2.size() >= 3) begin
      checkOutput("d2_b0", 64'(got2[0]), 64'({32'h0000_FFFF, 2'b01, 1'b0}));
      checkOutput("d2_b1", 64'(got2[1]), 64'({32'h8000_1234, 2'b11, 1'b0}));
      checkOutput("d2_b2", 64'(got2[2]), 64'({32'hFFFF_0000, 2'b10, 1'b1}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
